// File: rtl/counter_ext.sv
// counter_ext: widens the 4-bit mode counter into one LOW_W+UPPER_W count.
// The counter's carry and load pulses drive an UPPER_W-bit upper field.
// Sticky flags record wraps of the upper field and dropped snapshot requests.
// A single-entry valid/ready port hands out snapshots of the wide count.
//
// Snapshot handshake: snap_valid is high while snap_data holds a snapshot that
// has not been accepted. A transfer happens on any edge with snap_valid and
// snap_ready both high. While snap_valid is high, snap_data stays stable
// until that transfer. On the transfer edge, a snap_req recaptures the count
// (a back-to-back transfer); without snap_req the port empties. A snap_req
// that arrives while snap_valid is high and snap_ready is low is dropped and
// sets snap_miss. snap_ready is ignored while snap_valid is low.
module counter_ext #(
    parameter int LOW_W   = 4,
    parameter int UPPER_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               mode_in,
    input  logic [UPPER_W-1:0]       d_hi,
    input  logic [LOW_W-1:0]         q_in,
    input  logic                     rco_in,
    input  logic                     load_in,
    input  logic                     clr_flags,
    input  logic                     snap_req,
    input  logic                     snap_ready,
    output logic [LOW_W+UPPER_W-1:0] count_out,
    output logic                     snap_valid,
    output logic [LOW_W+UPPER_W-1:0] snap_data,
    output logic                     ovf,
    output logic                     unf,
    output logic                     snap_miss,
    output logic                     snap_state
);

    localparam int CW = LOW_W + UPPER_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FULL = 1'b1
    } snap_state_t;

    snap_state_t        state, state_next;
    logic [1:0]         mode_d;
    logic [UPPER_W-1:0] d_hi_d;
    logic [UPPER_W-1:0] upper, upper_next;
    logic [LOW_W-1:0]   q_d;
    logic               ovf_set, unf_set;
    logic               capture, miss_set;

    // The counter's registered outputs lag the mode bus by one cycle.
    // This delay lines mode and the load value up with the counter's pulses.
    always_ff @(posedge clk) begin
        mode_d <= mode_in;
        d_hi_d <= d_hi;
    end

    // Upper-field update: a load beats a carry. mode_d sets the carry direction.
    always_comb begin
        upper_next = upper;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        if (load_in) begin
            upper_next = d_hi_d;
        end else if (rco_in) begin
            case (mode_d)
                2'b00, 2'b10: begin
                    upper_next = upper + UPPER_W'(1);
                    ovf_set    = (upper == '1);
                end
                2'b01: begin
                    upper_next = upper - UPPER_W'(1);
                    unf_set    = (upper == '0);
                end
                default: ;
            endcase
        end
    end

    // Wide count registers and sticky flags. A clear beats a same-cycle set.
    always_ff @(posedge clk) begin
        if (reset) begin
            upper     <= '0;
            q_d       <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            snap_miss <= 1'b0;
        end else begin
            upper     <= upper_next;
            q_d       <= q_in;
            ovf       <= clr_flags ? 1'b0 : (ovf | ovf_set);
            unf       <= clr_flags ? 1'b0 : (unf | unf_set);
            snap_miss <= clr_flags ? 1'b0 : (snap_miss | miss_set);
        end
    end

    assign count_out = {upper, q_d};

    // Snapshot FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Snapshot FSM next state, capture strobe and drop detection
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        miss_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (snap_req) begin
                    capture    = 1'b1;
                    state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (snap_ready) begin
                    if (snap_req) capture    = 1'b1;
                    else          state_next = S_IDLE;
                end else if (snap_req) begin
                    miss_set = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The snapshot register samples the registered wide count on capture
    always_ff @(posedge clk) begin
        if (reset)        snap_data <= '0;
        else if (capture) snap_data <= count_out;
    end

    assign snap_valid = (state == S_FULL);
    assign snap_state = state;

endmodule

// File: tb/tb_counter_ext.sv
// Testbench for counter_ext. It runs directed scenarios and then random traffic.
// A behavioural model computes the expected values after every clock edge.
module tb_counter_ext;

  localparam int LOW_W   = 4;
  localparam int UPPER_W = 12;
  localparam int CW      = LOW_W + UPPER_W;
  localparam int UMAX    = (1 << UPPER_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         mode_in;
  logic [UPPER_W-1:0] d_hi;
  logic [LOW_W-1:0]   q_in;
  logic               rco_in, load_in, clr_flags, snap_req, snap_ready;
  logic [CW-1:0]      count_out, snap_data;
  logic               snap_valid, ovf, unf, snap_miss, snap_state;

  always #5 clk = ~clk;

  counter_ext #(.LOW_W(LOW_W), .UPPER_W(UPPER_W)) dut (
    .clk(clk), .reset(reset), .mode_in(mode_in), .d_hi(d_hi), .q_in(q_in),
    .rco_in(rco_in), .load_in(load_in), .clr_flags(clr_flags),
    .snap_req(snap_req), .snap_ready(snap_ready), .count_out(count_out),
    .snap_valid(snap_valid), .snap_data(snap_data), .ovf(ovf), .unf(unf),
    .snap_miss(snap_miss), .snap_state(snap_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  int m_upper, m_q, m_mode_d, m_dhi_d;
  logic [CW-1:0] m_last_data;
  logic [CW-1:0] exp_q[$];   // pending (unaccepted) snapshot, at most one entry
  bit m_ovf, m_unf, m_miss;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge, using the inputs applied before the edge.
  task automatic model_edge();
    int cur_count;
    bit ovf_ev, unf_ev, miss_ev;
    ovf_ev = 0; unf_ev = 0; miss_ev = 0;
    cur_count = m_upper * (1 << LOW_W) + m_q;
    if (reset) begin
      m_upper = 0; m_q = 0; m_last_data = '0; exp_q.delete();
      m_ovf = 0; m_unf = 0; m_miss = 0;
    end else begin
      if (load_in) m_upper = m_dhi_d;
      else if (rco_in && (m_mode_d == 0 || m_mode_d == 2)) begin
        if (m_upper == UMAX) begin m_upper = 0; ovf_ev = 1; end
        else m_upper = m_upper + 1;
      end else if (rco_in && m_mode_d == 1) begin
        if (m_upper == 0) begin m_upper = UMAX; unf_ev = 1; end
        else m_upper = m_upper - 1;
      end
      m_q = int'(q_in);
      if (exp_q.size() == 0) begin
        if (snap_req) begin exp_q.push_back(CW'(cur_count)); m_last_data = CW'(cur_count); end
      end else if (snap_ready) begin
        void'(exp_q.pop_front());
        if (snap_req) begin exp_q.push_back(CW'(cur_count)); m_last_data = CW'(cur_count); end
      end else if (snap_req) begin
        miss_ev = 1;
      end
      if (clr_flags) begin m_ovf = 0; m_unf = 0; m_miss = 0; end
      else begin m_ovf |= ovf_ev; m_unf |= unf_ev; m_miss |= miss_ev; end
    end
    m_mode_d = int'(mode_in);
    m_dhi_d  = int'(d_hi);
  endtask

  task automatic compare_all();
    check("count_out", 32'(count_out), 32'(m_upper * (1 << LOW_W) + m_q));
    check("snap_valid", 32'(snap_valid), 32'(exp_q.size() != 0));
    check("snap_data", 32'(snap_data), 32'(m_last_data));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("unf", 32'(unf), 32'(m_unf));
    check("snap_miss", 32'(snap_miss), 32'(m_miss));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [1:0] m, input logic [UPPER_W-1:0] dh, input logic [LOW_W-1:0] q,
                       input logic rco, input logic ld, input logic clr, input logic req, input logic rdy);
    mode_in = m; d_hi = dh; q_in = q; rco_in = rco; load_in = ld;
    clr_flags = clr; snap_req = req; snap_ready = rdy;
  endtask

  task automatic drive_random();
    reset      = ($urandom_range(63) == 0);
    mode_in    = 2'($urandom_range(3));
    d_hi       = UPPER_W'($urandom);
    q_in       = LOW_W'($urandom);
    rco_in     = ($urandom_range(2) == 0);
    load_in    = ($urandom_range(7) == 0);
    clr_flags  = ($urandom_range(15) == 0);
    snap_req   = ($urandom_range(3) == 0);
    snap_ready = ($urandom_range(1) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_upper = 0; m_q = 0; m_mode_d = 0; m_dhi_d = 0; m_last_data = '0;
    m_ovf = 0; m_unf = 0; m_miss = 0;

    // Reset with random inputs: every output must read zero.
    for (int i = 0; i < 3; i++) begin
      drive_random();
      reset = 1'b1;
      tick();
      check("rst_count", 32'(count_out), 32'h0);
      check("rst_valid", 32'(snap_valid), 32'h0);
      check("rst_data", 32'(snap_data), 32'h0);
      check("rst_flags", 32'({ovf, unf, snap_miss}), 32'h0);
    end
    reset = 1'b0;

    // Mode 10 carry out of the low nibble.
    drive(2'b10, 12'h000, 4'd14, 0, 0, 0, 0, 0); tick();
    drive(2'b10, 12'h000, 4'd15, 0, 0, 0, 0, 0); tick();
    drive(2'b10, 12'h000, 4'd0, 1, 0, 0, 0, 0);  tick();
    check("up1_wrap", 32'(count_out), 32'h0010);

    // Overflow from 0xFFF with mode 00, then clear.
    drive(2'b11, 12'hFFF, 4'd0, 0, 0, 0, 0, 0); tick();
    drive(2'b00, 12'h000, 4'd0, 0, 1, 0, 0, 0); tick();
    check("load_fff", 32'(count_out[CW-1:LOW_W]), 32'hFFF);
    drive(2'b00, 12'h000, 4'd1, 1, 0, 0, 0, 0); tick();
    check("ovf_upper", 32'(count_out[CW-1:LOW_W]), 32'h000);
    check("ovf_set", 32'(ovf), 32'h1);
    drive(2'b00, 12'h000, 4'd1, 0, 0, 1, 0, 0); tick();
    check("ovf_clr", 32'(ovf), 32'h0);

    // Underflow from 0x000 with mode 01.
    drive(2'b01, 12'h000, 4'd1, 0, 0, 0, 0, 0); tick();
    drive(2'b01, 12'h000, 4'd0, 1, 0, 0, 0, 0); tick();
    check("unf_upper", 32'(count_out[CW-1:LOW_W]), 32'hFFF);
    check("unf_set", 32'(unf), 32'h1);

    // Load beats a same-cycle carry.
    drive(2'b10, 12'hA5C, 4'd3, 0, 0, 0, 0, 0); tick();
    drive(2'b10, 12'h000, 4'd3, 1, 1, 0, 0, 0); tick();
    check("load_vs_rco", 32'(count_out[CW-1:LOW_W]), 32'hA5C);

    // Snapshot: capture, stall with a dropped request, then back-to-back transfer.
    drive(2'b11, 12'h123, 4'd4, 0, 0, 1, 0, 0); tick();
    drive(2'b10, 12'h000, 4'd4, 0, 1, 0, 0, 0); tick();
    check("count_1234", 32'(count_out), 32'h1234);
    drive(2'b10, 12'h000, 4'd4, 0, 0, 0, 1, 0); tick();
    check("snap_cap_v", 32'(snap_valid), 32'h1);
    check("snap_cap_d", 32'(snap_data), 32'h1234);
    drive(2'b10, 12'h000, 4'd7, 0, 0, 0, 0, 0); tick();
    drive(2'b10, 12'h000, 4'd7, 0, 0, 0, 1, 0); tick();
    drive(2'b10, 12'h000, 4'd7, 0, 0, 0, 0, 0); tick();
    check("snap_hold", 32'(snap_data), 32'h1234);
    check("snap_miss", 32'(snap_miss), 32'h1);
    drive(2'b10, 12'h000, 4'd7, 0, 0, 0, 1, 1); tick();
    check("snap_b2b_v", 32'(snap_valid), 32'h1);
    check("snap_b2b_d", 32'(snap_data), 32'h1237);
    drive(2'b10, 12'h000, 4'd7, 0, 0, 0, 0, 1); tick();
    check("snap_drain", 32'(snap_valid), 32'h0);

    // Reset in the middle of a pending snapshot.
    drive(2'b10, 12'h000, 4'd7, 0, 0, 0, 1, 0); tick();
    reset = 1'b1; tick();
    check("rst_mid_snap", 32'(snap_valid), 32'h0);
    reset = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
